cva6_pma_region_table: RTL and testbench
========================================

// Module: cva6_pma_region_table
// PURPOSE
// - Runtime-programmable PMA table; replaces static execute/cached/non-idempotent region rules.
// - Sits between the MMU/LSU/frontend and the memory system.
// - Answers, per physical address, whether the address is executable, cacheable and idempotent.
// - Adds NrRules generic rules with a write/readback port, a registered lookup pipeline and a change epoch.
// PARAMETERS
// - NrRules      8        number of region rules (1..32)
// - AddrWidth    64       physical address width
// - EpochWidth   4        width of table-change counter
// - ResetRules   '0       pma_rule_t[NrRules] table contents after reset
// - DefaultAttr  '0       attributes returned when no rule hits
// PORTS
// - clk_i         in   1                     clock
// - rst_ni        in   1                     asynchronous reset, active-low
// - cfg_req_i     in   1                     config access request
// - cfg_we_i      in   1                     1 = write, 0 = read
// - cfg_idx_i     in   $clog2(NrRules)       rule index
// - cfg_wdata_i   in   pma_rule_t            rule to write
// - cfg_gnt_o     out  1                     access granted this cycle
// - cfg_rdata_o   out  pma_rule_t            readback, valid the cycle after grant
// - cfg_err_o     out  1                     write refused (idx >= NrRules, or locked), cycle after grant
// - epoch_o       out  EpochWidth            increments on every accepted write
// - lu_valid_i    in   1                     lookup request valid
// - lu_ready_o    out  1                     lookup request accepted when valid & ready
// - lu_addr_i     in   AddrWidth             physical address
// - lu_valid_o    out  1                     result valid
// - lu_ready_i    in   1                     result consumed
// - lu_hit_o      out  1                     some rule matched
// - lu_idx_o      out  $clog2(NrRules)       index of winning rule
// - lu_attr_o     out  pma_attr_t            {exec, cached, nonidem} of winner, else DefaultAttr
// BEHAVIOUR
// - Reset: table = ResetRules; epoch_o = 0; lu_valid_o = 0; cfg_gnt_o = 0;
//   cfg_err_o = 0; cfg_rdata_o = 0; lu_hit_o/lu_idx_o/lu_attr_o = 0.
// - Reset asserted mid-operation drops any in-flight result and restores ResetRules.
// - Match rule i:
//   - rule.en & (addr >= base) & (addr < base+len).
//   - The sum is computed in AddrWidth+1 bits, so there is no wrap.
//   - len == 0 never matches.
// - Priority: lowest matching index wins; lu_hit_o = 0 -> lu_idx_o = 0, attr = DefaultAttr.
// - Lookup is 1-cycle latency via a single output register.
//   - lu_ready_o = !lu_valid_o | lu_ready_i.
//   - Result is held stable while lu_valid_o & !lu_ready_i.
//   - Back-to-back accepts give one result per cycle.
// - Config:
//   - cfg_gnt_o = cfg_req_i, combinational; an access is always granted.
//   - A write updates the table at the clock edge; a read returns the entry next cycle.
//   - Out-of-range idx: write ignored, cfg_err_o = 1; read returns 0.
// - Write and lookup in the same cycle: the lookup sees the old table; the new entry applies from the next accepted lookup.
// - A held (stalled) result is not re-evaluated after a table write.
// - epoch_o wraps modulo 2^EpochWidth. Consumers flush TLB/cache PMA copies when it changes.
// CONFIGURATION
// - Macro CVA6_PMA_RULE_LOCK_EN.
// - Defined:
//   - pma_rule_t carries a lock bit.
//   - A write to a locked rule is refused: cfg_err_o = 1, table and epoch unchanged.
//   - Lock clears only on reset.
//   - Writing lock=1 takes effect with that write.
// - Undefined: no lock field; all in-range writes are accepted.
// STRUCTURE
// - cva6_pma_pkg:
//   - pma_attr_t {exec, cached, nonidem}.
//   - pma_rule_t {en, [lock], attr, base, len}.
//   - Max NrRules constant.
// - Sub-module cva6_pma_rule_match: one rule comparator, instantiated NrRules times in a generate loop.
// - A priority encoder and the output register live in the top module.
// TESTING
// - Reset with ResetRules[0] = {en, base 0x8000_0000, len 0x4000_0000, cached}, then look up 0xBFFF_FFFF:
//   hit = 1, idx = 0, cached = 1. Look up 0xC000_0000: hit = 0, DefaultAttr.
// - Overlapping rules 2 and 5 both cover 0x1_0000; lookup -> idx = 2.
//   Disable rule 2 -> idx = 5, epoch + 1.
// - Write rule 3 and look up its range in the same cycle -> old result. Next-cycle lookup -> new attr.
// - Hold lu_ready_i = 0 for 3 cycles with lu_valid_i = 1:
//   - lu_ready_o = 0;
//   - result stable;
//   - no request dropped or duplicated across 4 back-to-back addresses.
// - Rule base 0xFFFF_FFFF_FFFF_F000, len 0x2000: addr 0xFFFF_FFFF_FFFF_FFFF hits; addr 0x0 does not.
//   len = 0 never hits.
// - CVA6_PMA_RULE_LOCK_EN: write lock = 1 to rule 1, then rewrite it -> cfg_err_o = 1, readback unchanged,
//   epoch unchanged. Write idx = NrRules -> cfg_err_o = 1.

Source files
------------

// File: rtl/cva6_pma_pkg.sv
// Types shared by the PMA region table, its interface and the bench.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Optional feature macro: CVA6_PMA_RULE_LOCK_EN adds a per-rule lock bit to pma_rule_t.
package cva6_pma_pkg;

    // Upper bound on the number of rules a table instance may carry.
    localparam int unsigned PMA_MAX_RULES = 32;
    // Storage width of base/len. A table may compare on fewer low bits.
    localparam int unsigned PMA_ADDR_W    = 64;

    typedef struct packed {
        logic exec;
        logic cached;
        logic nonidem;
    } pma_attr_t;

    typedef struct packed {
        logic                  en;
`ifdef CVA6_PMA_RULE_LOCK_EN
        logic                  lock;
`endif
        pma_attr_t             attr;
        logic [PMA_ADDR_W-1:0] base;
        logic [PMA_ADDR_W-1:0] len;
    } pma_rule_t;

    // Index width for n rules. It never returns 0, so a 1-rule table still gets a real port.
    function automatic int unsigned pma_idx_w(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/cva6_pma_region_table_if.sv
// Bundles the config port and the lookup request/result channels of the PMA table.
// Latency: n/a (wiring only).
// Backpressure: the lookup request uses lu_valid_i/lu_ready_o and the result uses lu_valid_o/lu_ready_i.
// Ports: slave = table side (cfg_* in, cfg_gnt/rdata/err and epoch out, lu_* request in, result out);
//        master = requester side, with every direction reversed.
interface cva6_pma_region_table_if #(
    parameter int unsigned NrRules    = 8,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned EpochWidth = 4
);
    import cva6_pma_pkg::*;

    localparam int unsigned IdxW = pma_idx_w(NrRules);

    // Config access
    logic                  cfg_req_i;
    logic                  cfg_we_i;
    logic [IdxW-1:0]       cfg_idx_i;
    pma_rule_t             cfg_wdata_i;
    logic                  cfg_gnt_o;
    pma_rule_t             cfg_rdata_o;
    logic                  cfg_err_o;
    logic [EpochWidth-1:0] epoch_o;

    // Lookup request and result
    logic                  lu_valid_i;
    logic                  lu_ready_o;
    logic [AddrWidth-1:0]  lu_addr_i;
    logic                  lu_valid_o;
    logic                  lu_ready_i;
    logic                  lu_hit_o;
    logic [IdxW-1:0]       lu_idx_o;
    pma_attr_t             lu_attr_o;

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_wdata_i,
        output cfg_gnt_o, cfg_rdata_o, cfg_err_o, epoch_o,
        input  lu_valid_i, lu_addr_i, lu_ready_i,
        output lu_ready_o, lu_valid_o, lu_hit_o, lu_idx_o, lu_attr_o
    );

    modport master (
        output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_wdata_i,
        input  cfg_gnt_o, cfg_rdata_o, cfg_err_o, epoch_o,
        output lu_valid_i, lu_addr_i, lu_ready_i,
        input  lu_ready_o, lu_valid_o, lu_hit_o, lu_idx_o, lu_attr_o
    );

endinterface

// File: rtl/cva6_pma_rule_match.sv
// Single-region comparator: en & base <= addr < base+len, with no wraparound.
// Latency: combinational.
// Backpressure: none.
// Ports: i_en/i_base/i_len describe the rule, i_addr is the probed address, o_match is the hit flag.
module cva6_pma_rule_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic                 i_en,
    input  logic [AddrWidth-1:0] i_base,
    input  logic [AddrWidth-1:0] i_len,
    input  logic [AddrWidth-1:0] i_addr,
    output logic                 o_match
);

    // The end address is formed one bit wider, so a region that touches the top of memory
    // ends at 2^AddrWidth instead of wrapping back to 0.
    logic [AddrWidth:0] w_end;
    logic               w_ge_base;
    logic               w_lt_end;

    assign w_end     = {1'b0, i_base} + {1'b0, i_len};
    assign w_ge_base = (i_addr >= i_base);
    assign w_lt_end  = ({1'b0, i_addr} < w_end);

    // A region with len == 0 is empty: base <= addr < base cannot hold. The explicit term
    // makes that intent obvious.
    assign o_match = i_en & (i_len != '0) & w_ge_base & w_lt_end;

endmodule

// File: rtl/cva6_pma_region_table.sv
// Runtime-programmable PMA table. It reports, per physical address, the lowest-index matching rule
// and that rule's {exec, cached, nonidem}. With no match it reports DefaultAttr.
// Latency: lookup takes 1 cycle through one output register. Config reads and write errors appear
//          the cycle after grant.
// Backpressure: lu_ready_o = !lu_valid_o | lu_ready_i. A stalled result is held and not re-evaluated.
//               Config accesses are always granted.
// Ports: clk_i, rst_ni (async, active-low). bus (slave modport) carries the config port, epoch_o
//        and the lookup channels.
// Optional feature macro: CVA6_PMA_RULE_LOCK_EN (sticky per-rule write lock, cleared only by reset).
module cva6_pma_region_table
    import cva6_pma_pkg::*;
#(
    parameter int unsigned             NrRules     = 8,
    parameter int unsigned             AddrWidth   = 64,
    parameter int unsigned             EpochWidth  = 4,
    parameter pma_rule_t [NrRules-1:0] ResetRules  = '0,
    parameter pma_attr_t               DefaultAttr = '0
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    cva6_pma_region_table_if.slave bus
);

    localparam int unsigned IdxW = pma_idx_w(NrRules);

    // Rule storage
    pma_rule_t             r_table [NrRules];

    // Config path
    logic                  w_idx_ok;
    logic                  w_locked;
    logic                  w_wr_ok;
    pma_rule_t             w_sel_rule;
    pma_rule_t             r_cfg_rdata;
    logic                  r_cfg_err;
    logic [EpochWidth-1:0] r_epoch;

    // Lookup path
    logic [NrRules-1:0]    w_match;
    logic                  w_hit;
    logic [IdxW-1:0]       w_idx;
    pma_attr_t             w_attr;
    logic                  w_lu_rdy;
    logic                  w_lu_acc;
    logic                  r_lu_vld;
    logic                  r_lu_hit;
    logic [IdxW-1:0]       r_lu_idx;
    pma_attr_t             r_lu_attr;

    // ------------------------------------------------------------------
    // Comparators, one per rule. They always see the registered table, so a lookup in the
    // same cycle as a write still sees the old entry.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < int'(NrRules); g++) begin : g_match
        cva6_pma_rule_match #(
            .AddrWidth (AddrWidth)
        ) u_match (
            .i_en    (r_table[g].en),
            .i_base  (r_table[g].base[AddrWidth-1:0]),
            .i_len   (r_table[g].len[AddrWidth-1:0]),
            .i_addr  (bus.lu_addr_i),
            .o_match (w_match[g])
        );
    end

    // Priority encoder: the lowest index wins.
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_attr = DefaultAttr;
        for (int i = 0; i < int'(NrRules); i++) begin
            if (w_match[i] && !w_hit) begin
                w_hit  = 1'b1;
                w_idx  = IdxW'(i);
                w_attr = r_table[i].attr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Config decode
    // ------------------------------------------------------------------
    // The index port can encode more values than there are rules when NrRules is not a
    // power of two.
    assign w_idx_ok = ({1'b0, bus.cfg_idx_i} < (IdxW+1)'(NrRules));

    // Selecting by comparison (not by direct indexing) means an out-of-range index yields
    // all-zero rather than an out-of-bounds read.
    always_comb begin
        w_sel_rule = '0;
        for (int i = 0; i < int'(NrRules); i++) begin
            if (bus.cfg_idx_i == IdxW'(i)) begin
                w_sel_rule = r_table[i];
            end
        end
    end

`ifdef CVA6_PMA_RULE_LOCK_EN
    // The lock field of the stored entry decides. A write that sets lock is itself accepted.
    assign w_locked = w_sel_rule.lock;
`else
    assign w_locked = 1'b0;
`endif

    assign w_wr_ok = bus.cfg_req_i & bus.cfg_we_i & w_idx_ok & ~w_locked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRules); i++) begin
                r_table[i] <= ResetRules[i];
            end
            r_epoch     <= '0;
            r_cfg_rdata <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            // The error flag is a one-cycle pulse for each refused write.
            r_cfg_err <= bus.cfg_req_i & bus.cfg_we_i & ~w_wr_ok;
            // Readback holds the last read. w_sel_rule is already zero when the index is out of range.
            if (bus.cfg_req_i && !bus.cfg_we_i) begin
                r_cfg_rdata <= w_sel_rule;
            end
            if (w_wr_ok) begin
                for (int i = 0; i < int'(NrRules); i++) begin
                    if (bus.cfg_idx_i == IdxW'(i)) begin
                        r_table[i] <= bus.cfg_wdata_i;
                    end
                end
                // Consumers compare the epoch to decide when to flush cached PMA copies.
                // It wraps freely.
                r_epoch <= r_epoch + EpochWidth'(1);
            end
        end
    end

    assign bus.cfg_gnt_o   = bus.cfg_req_i;
    assign bus.cfg_rdata_o = r_cfg_rdata;
    assign bus.cfg_err_o   = r_cfg_err;
    assign bus.epoch_o     = r_epoch;

    // ------------------------------------------------------------------
    // Lookup output register. The result loads only on accept, so a held result never picks
    // up a later table write.
    // ------------------------------------------------------------------
    assign w_lu_rdy = ~r_lu_vld | bus.lu_ready_i;
    assign w_lu_acc = bus.lu_valid_i & w_lu_rdy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lu_vld  <= 1'b0;
            r_lu_hit  <= 1'b0;
            r_lu_idx  <= '0;
            r_lu_attr <= '0;
        end else if (w_lu_acc) begin
            r_lu_vld  <= 1'b1;
            r_lu_hit  <= w_hit;
            r_lu_idx  <= w_idx;
            r_lu_attr <= w_attr;
        end else if (bus.lu_ready_i) begin
            r_lu_vld  <= 1'b0;
        end
    end

    assign bus.lu_ready_o = w_lu_rdy;
    assign bus.lu_valid_o = r_lu_vld;
    assign bus.lu_hit_o   = r_lu_hit;
    assign bus.lu_idx_o   = r_lu_idx;
    assign bus.lu_attr_o  = r_lu_attr;

endmodule

// File: tb/tb_cva6_pma_region_table.sv
// Bench for cva6_pma_region_table: vector table plus hand-written sequences, with a result scoreboard.
// Latency: expects one cycle from accept to result.
// Backpressure: drives lu_ready_i low to stall the result channel.
`timescale 1ns/1ps
module tb_cva6_pma_region_table;
    import cva6_pma_pkg::*;

    localparam int unsigned NR = 6;
    localparam int unsigned AW = 64;
    localparam int unsigned EW = 4;

    localparam pma_attr_t A_DEF    = 3'b001;
    localparam pma_attr_t A_CACHED = 3'b010;
    localparam pma_attr_t A_EXEC   = 3'b100;
    localparam pma_attr_t A_CN     = 3'b011;
    localparam pma_attr_t A_ALL    = 3'b111;
    localparam pma_attr_t A_EN     = 3'b101;

    typedef pma_rule_t [NR-1:0] rules_t;

    function automatic pma_rule_t mk_rule(input logic en, input pma_attr_t at,
                                          input logic [63:0] b, input logic [63:0] l);
        pma_rule_t r;
        r      = '0;
        r.en   = en;
        r.attr = at;
        r.base = b;
        r.len  = l;
        return r;
    endfunction

    function automatic rules_t reset_rules();
        rules_t r;
        r    = '0;
        r[0] = mk_rule(1'b1, A_CACHED, 64'h8000_0000, 64'h4000_0000);
        return r;
    endfunction

    localparam rules_t RST_RULES = reset_rules();

    typedef struct {
        logic [63:0] addr;
        logic        hit;
        logic [2:0]  idx;
        pma_attr_t   attr;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic        hit;
        logic [2:0]  idx;
        pma_attr_t   attr;
    } exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    cva6_pma_region_table_if #(.NrRules(NR), .AddrWidth(AW), .EpochWidth(EW)) bus ();

    cva6_pma_region_table #(
        .NrRules     (NR),
        .AddrWidth   (AW),
        .EpochWidth  (EW),
        .ResetRules  (RST_RULES),
        .DefaultAttr (A_DEF)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_sent   = 0;
    int   n_got    = 0;
    exp_t q[$];
    exp_t mon_e;
    vec_t vecs[12];

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: pop and compare every result the DUT hands over.
    always @(negedge clk_i) begin
        if (rst_ni && bus.lu_valid_o && bus.lu_ready_i) begin
            n_got++;
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check($sformatf("lookup_%0h", mon_e.addr),
                      {bus.lu_hit_o, bus.lu_idx_o, bus.lu_attr_o},
                      {mon_e.hit, mon_e.idx, mon_e.attr});
            end
        end
    end

    // Presents one request. The expectation is pushed the cycle it is accepted.
    // lu_valid_i is left high so calls can run back to back.
    task automatic send(input logic [63:0] a, input logic eh, input logic [2:0] ei, input pma_attr_t ea);
        int b;
        exp_t e;
        b = 0;
        bus.lu_valid_i = 1'b1;
        bus.lu_addr_i  = a;
        @(negedge clk_i);
        while (!bus.lu_ready_o && b < 50) begin
            b++;
            @(negedge clk_i);
        end
        if (b >= 50) begin
            check($sformatf("accept_timeout_%0h", a), 0, 1);
        end else begin
            e.addr = a; e.hit = eh; e.idx = ei; e.attr = ea;
            q.push_back(e);
            n_sent++;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic drain(input string nm);
        int b;
        b = 0;
        bus.lu_valid_i = 1'b0;
        while (q.size() != 0 && b < 20) begin
            b++;
            @(negedge clk_i);
        end
        check({nm, "_drain"}, q.size(), 0);
        @(posedge clk_i); #1;
    endtask

    task automatic cfg_wr(input logic [2:0] idx, input pma_rule_t wd, input logic exp_err, input string nm);
        bus.cfg_req_i   = 1'b1;
        bus.cfg_we_i    = 1'b1;
        bus.cfg_idx_i   = idx;
        bus.cfg_wdata_i = wd;
        @(negedge clk_i);
        check({nm, "_gnt"}, bus.cfg_gnt_o, 1);
        @(posedge clk_i); #1;
        bus.cfg_req_i = 1'b0;
        bus.cfg_we_i  = 1'b0;
        check({nm, "_err"}, bus.cfg_err_o, exp_err);
    endtask

    task automatic cfg_rd(input logic [2:0] idx, input pma_rule_t exp_rd, input string nm);
        bus.cfg_req_i = 1'b1;
        bus.cfg_we_i  = 1'b0;
        bus.cfg_idx_i = idx;
        @(posedge clk_i); #1;
        bus.cfg_req_i = 1'b0;
        check({nm, "_rdata"}, bus.cfg_rdata_o, exp_rd);
    endtask

    initial begin
        pma_rule_t r;
        bus.cfg_req_i   = 1'b0;
        bus.cfg_we_i    = 1'b0;
        bus.cfg_idx_i   = '0;
        bus.cfg_wdata_i = '0;
        bus.lu_valid_i  = 1'b0;
        bus.lu_addr_i   = '0;
        bus.lu_ready_i  = 1'b1;

        vecs[0]  = '{64'hBFFF_FFFF,            1'b1, 3'd0, A_CACHED};
        vecs[1]  = '{64'hC000_0000,            1'b0, 3'd0, A_DEF};
        vecs[2]  = '{64'h8000_0000,            1'b1, 3'd0, A_CACHED};
        vecs[3]  = '{64'h7FFF_FFFF,            1'b0, 3'd0, A_DEF};
        vecs[4]  = '{64'h1_0000,               1'b1, 3'd2, A_EXEC};
        vecs[5]  = '{64'h1_0FFF,               1'b1, 3'd2, A_EXEC};
        vecs[6]  = '{64'h1_1000,               1'b1, 3'd5, A_CN};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 3'd4, A_ALL};
        vecs[8]  = '{64'h0,                    1'b0, 3'd0, A_DEF};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_EFFF,  1'b0, 3'd0, A_DEF};
        vecs[10] = '{64'h2000_0000,            1'b0, 3'd0, A_DEF};
        vecs[11] = '{64'h1_8000,               1'b0, 3'd0, A_DEF};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_lu_valid", bus.lu_valid_o, 0);
        check("rst_epoch",    bus.epoch_o, 0);
        check("rst_gnt",      bus.cfg_gnt_o, 0);
        check("rst_err",      bus.cfg_err_o, 0);
        check("rst_rdata",    bus.cfg_rdata_o, 0);
        check("rst_result",   {bus.lu_hit_o, bus.lu_idx_o, bus.lu_attr_o}, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Lookups against the reset table
        for (int i = 0; i < 4; i++) send(vecs[i].addr, vecs[i].hit, vecs[i].idx, vecs[i].attr);
        drain("reset_tbl");
        cfg_rd(3'd0, RST_RULES[0], "rd_rule0");

        // Program overlapping rules, a top-of-memory rule and an empty rule
        cfg_wr(3'd2, mk_rule(1'b1, A_EXEC, 64'h1_0000, 64'h1000), 1'b0, "wr_r2");
        cfg_wr(3'd5, mk_rule(1'b1, A_CN,   64'h8000,   64'h1_0000), 1'b0, "wr_r5");
        cfg_wr(3'd4, mk_rule(1'b1, A_ALL,  64'hFFFF_FFFF_FFFF_F000, 64'h2000), 1'b0, "wr_r4");
        cfg_wr(3'd1, mk_rule(1'b1, A_EXEC, 64'h2000_0000, 64'h0), 1'b0, "wr_r1");
        check("epoch_after4", bus.epoch_o, 4);
        for (int i = 4; i < 12; i++) send(vecs[i].addr, vecs[i].hit, vecs[i].idx, vecs[i].attr);
        drain("prog_tbl");

        // Disable rule 2, so rule 5 takes over
        r = mk_rule(1'b0, A_EXEC, 64'h1_0000, 64'h1000);
        cfg_wr(3'd2, r, 1'b0, "dis_r2");
        check("epoch_dis", bus.epoch_o, 5);
        send(64'h1_0000, 1'b1, 3'd5, A_CN);
        drain("dis_r2");
        cfg_rd(3'd2, r, "rd_r2");

        // Out-of-range index
        cfg_rd(3'd6, '0, "rd_oob");
        cfg_wr(3'd6, mk_rule(1'b1, A_ALL, 64'h0, 64'h10), 1'b1, "wr_oob6");
        cfg_wr(3'd7, mk_rule(1'b1, A_ALL, 64'h0, 64'h10), 1'b1, "wr_oob7");
        check("epoch_oob", bus.epoch_o, 5);

        // Write and lookup in the same cycle: old table, then new
        bus.cfg_req_i   = 1'b1;
        bus.cfg_we_i    = 1'b1;
        bus.cfg_idx_i   = 3'd3;
        bus.cfg_wdata_i = mk_rule(1'b1, A_EN, 64'h4000_0000, 64'h1000);
        send(64'h4000_0000, 1'b0, 3'd0, A_DEF);
        bus.cfg_req_i = 1'b0;
        bus.cfg_we_i  = 1'b0;
        send(64'h4000_0000, 1'b1, 3'd3, A_EN);
        drain("same_cycle");
        check("epoch_same", bus.epoch_o, 6);

        // Stall the result channel for 3 cycles with a request pending
        bus.lu_ready_i = 1'b0;
        send(64'hBFFF_FFFF, 1'b1, 3'd0, A_CACHED);
        bus.lu_addr_i = 64'h4000_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("stall_rdy",  bus.lu_ready_o, 0);
            check("stall_hold", {bus.lu_valid_o, bus.lu_hit_o, bus.lu_idx_o, bus.lu_attr_o},
                                {1'b1, 1'b1, 3'd0, A_CACHED});
        end
        @(posedge clk_i); #1;
        bus.lu_ready_i = 1'b1;
        send(64'h4000_0000, 1'b1, 3'd3, A_EN);
        send(64'hC000_0000, 1'b0, 3'd0, A_DEF);
        send(64'h1_0000,    1'b1, 3'd5, A_CN);
        drain("stall");
        check("result_count", n_got, n_sent);

`ifdef CVA6_PMA_RULE_LOCK_EN
        // A locked rule refuses rewrites, leaving the table and epoch unchanged
        r = mk_rule(1'b1, A_EXEC, 64'h2000_0000, 64'h100);
        r.lock = 1'b1;
        cfg_wr(3'd1, r, 1'b0, "lock_set");
        check("epoch_lock_set", bus.epoch_o, 7);
        send(64'h2000_0080, 1'b1, 3'd1, A_EXEC);
        drain("lock");
        cfg_wr(3'd1, mk_rule(1'b1, A_ALL, 64'h2000_0000, 64'h200), 1'b1, "lock_rewrite");
        check("epoch_locked", bus.epoch_o, 7);
        cfg_rd(3'd1, r, "rd_locked");
`endif

        // Reset during a held result: the result is dropped and the table restored
        bus.lu_ready_i = 1'b0;
        send(64'h1_1000, 1'b1, 3'd5, A_CN);
        bus.lu_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        q.delete();
        #1;
        check("midrst_valid", bus.lu_valid_o, 0);
        check("midrst_epoch", bus.epoch_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        bus.lu_ready_i = 1'b1;
        @(posedge clk_i); #1;
        send(64'h1_1000,     1'b0, 3'd0, A_DEF);
        send(64'hBFFF_FFFF,  1'b1, 3'd0, A_CACHED);
        send(64'h2000_0080,  1'b0, 3'd0, A_DEF);
        drain("midrst");

        // Rule 1 is writable again. Then 16 more writes wrap the epoch back to 1.
        cfg_wr(3'd1, mk_rule(1'b1, A_EXEC, 64'h2000_0000, 64'h100), 1'b0, "post_rst_wr");
        for (int k = 0; k < 16; k++) begin
            cfg_wr(3'd3, mk_rule(1'b1, A_EN, 64'h4000_0000 + 64'(k), 64'h10), 1'b0, "wrap_wr");
        end
        check("epoch_wrap", bus.epoch_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
